// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch sequencer bundle: PC register side, instruction-memory handshake, redirect sources.
// master = fetch_redirect_ctrl, slave = pipeline/memory environment.
interface fetch_redirect_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic             stallF;
  logic             inst_req;
  logic [WIDTH-1:0] inst_addr;
  logic             inst_ack;
  logic             stall_ext;
  logic             exc_valid;
  logic             eret;
  logic [WIDTH-1:0] epc;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             discard;
  logic             addr_err;
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_discard_cnt;

  modport master (
    input  pc, inst_ack, stall_ext, exc_valid, eret, epc, br_valid, br_target,
    output pc_next, stallF, inst_req, inst_addr, discard, addr_err,
           perf_stall_cnt, perf_discard_cnt
  );

  modport slave (
    output pc, inst_ack, stall_ext, exc_valid, eret, epc, br_valid, br_target,
    input  pc_next, stallF, inst_req, inst_addr, discard, addr_err,
           perf_stall_cnt, perf_discard_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// IF-stage PC sequencer: next-PC select, imem req/ack handshake, buffered redirect while a fetch is out.
// Define FETCH_PERF_EN to build the stall/discard performance counters (tied to 0 otherwise).
module fetch_redirect_ctrl #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000,
  parameter logic [WIDTH-1:0] EXC_VEC  = 32'hbfc00380
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e           r_state, w_state_d;
  logic             r_pend_v, w_pend_v_d;
  logic [WIDTH-1:0] r_pend_pc, w_pend_pc_d;
  logic [1:0]       r_pend_pri, w_pend_pri_d;
  logic             r_err_done, w_err_done_d;

  logic [1:0]       w_new_pri;
  logic [WIDTH-1:0] w_new_pc;
  logic             w_redirect;
  logic             w_new_wins;
  logic [WIDTH-1:0] w_pc_seq;
  logic             w_pc_misal;
  logic [WIDTH-1:0] w_fetch_tgt;
  logic             w_stall;
  logic [WIDTH-1:0] w_next;
  logic             w_discard;
  logic             w_addr_err;

  // Priority rank: exception 3, eret 2, branch 1, none 0.
  always_comb begin
    w_new_pri = 2'd0;
    w_new_pc  = '0;
    if (bus.exc_valid) begin
      w_new_pri = 2'd3;
      w_new_pc  = EXC_VEC;
    end else if (bus.eret) begin
      w_new_pri = 2'd2;
      w_new_pc  = bus.epc;
    end else if (bus.br_valid) begin
      w_new_pri = 2'd1;
      w_new_pc  = bus.br_target;
    end
  end

  assign w_redirect  = (w_new_pri != 2'd0);
  assign w_new_wins  = w_redirect && (!r_pend_v || (w_new_pri >= r_pend_pri));
  assign w_pc_seq    = bus.pc + WIDTH'(4);
  assign w_pc_misal  = (bus.pc[1:0] != 2'b00);
  assign w_fetch_tgt = w_new_wins ? w_new_pc : (r_pend_v ? r_pend_pc : w_pc_seq);

  always_comb begin
    w_stall      = 1'b1;
    w_next       = RESET_PC;
    w_discard    = 1'b0;
    w_addr_err   = 1'b0;
    w_state_d    = r_state;
    w_pend_v_d   = r_pend_v;
    w_pend_pc_d  = r_pend_pc;
    w_pend_pri_d = r_pend_pri;
    w_err_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_addr_err = w_pc_misal && !r_err_done;
        if (w_redirect) begin
          w_stall = 1'b0;
          w_next  = w_new_pc;
        end else if (!w_pc_misal) begin
          w_state_d = StReq;
        end else begin
          w_err_done_d = 1'b1;
        end
      end
      StReq: begin
        if (bus.inst_ack) begin
          w_discard    = w_new_wins || r_pend_v;
          w_pend_v_d   = 1'b0;
          w_pend_pri_d = 2'd0;
          if (!bus.stall_ext) begin
            w_stall = 1'b0;
            w_next  = w_fetch_tgt;
          end else begin
            // Park the chosen target in pend_pc (pend_v stays low) until the stall releases.
            w_state_d   = StHold;
            w_pend_pc_d = w_fetch_tgt;
          end
        end else if (w_new_wins) begin
          w_pend_v_d   = 1'b1;
          w_pend_pc_d  = w_new_pc;
          w_pend_pri_d = w_new_pri;
        end
      end
      StHold: begin
        if (w_redirect) begin
          w_stall = 1'b0;
          w_next  = w_new_pc;
        end else if (!bus.stall_ext) begin
          w_stall = 1'b0;
          w_next  = r_pend_pc;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Every PC load re-checks alignment before issuing the next request.
    if (!w_stall) begin
      w_state_d = (w_next[1:0] != 2'b00) ? StIdle : StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pend_v   <= 1'b0;
      r_pend_pc  <= '0;
      r_pend_pri <= 2'd0;
      r_err_done <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pend_v   <= w_pend_v_d;
      r_pend_pc  <= w_pend_pc_d;
      r_pend_pri <= w_pend_pri_d;
      r_err_done <= w_err_done_d;
    end
  end

  assign bus.stallF    = rst | w_stall;
  assign bus.pc_next   = rst ? RESET_PC : w_next;
  assign bus.discard   = !rst && w_discard;
  assign bus.addr_err  = !rst && w_addr_err;
  assign bus.inst_req  = !rst && (r_state == StReq);
  assign bus.inst_addr = bus.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_discard_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt   <= 32'd0;
      r_perf_discard_cnt <= 32'd0;
    end else begin
      if ((r_state == StReq) && w_stall) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_discard) r_perf_discard_cnt <= r_perf_discard_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt   = r_perf_stall_cnt;
  assign bus.perf_discard_cnt = r_perf_discard_cnt;
`else
  assign bus.perf_stall_cnt   = 32'd0;
  assign bus.perf_discard_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic, all checked against a
// behavioural fetch model that also plays the external PC register.
module tb_fetch_redirect_ctrl;
  localparam logic [31:0] ResetPc = 32'hbfc00000;
  localparam logic [31:0] ExcVec  = 32'hbfc00380;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_redirect_ctrl_if #(.WIDTH(32)) bus ();

  fetch_redirect_ctrl #(
    .WIDTH   (32),
    .RESET_PC(ResetPc),
    .EXC_VEC (ExcVec)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: what the fetch unit is doing, not how it is encoded.
  bit          m_fetching;   // a request is out, waiting for ack
  bit          m_held;       // fetch returned, waiting for downstream to release
  bit          m_err_rep;    // misalignment already reported for the current idle PC
  int          m_pend_rank;  // 0 = nothing buffered
  logic [31:0] m_pend_pc;
  logic [31:0] m_hold_pc;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_disc_cnt;
  logic [31:0] pc_reg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit ack, input bit stl, input bit exc, input bit er,
                       input bit br, input logic [31:0] epc_v, input logic [31:0] brt_v);
    int          rank;
    logic [31:0] tgt, dest, e_next, exp_sc, exp_dc;
    bit          e_req, e_stall, e_disc, e_err, chk_next;
    @(posedge clk);
    #1;
    bus.pc        = pc_reg;
    rst           = r;
    bus.inst_ack  = ack;
    bus.stall_ext = stl;
    bus.exc_valid = exc;
    bus.eret      = er;
    bus.epc       = epc_v;
    bus.br_valid  = br;
    bus.br_target = brt_v;
    #1;
`ifdef FETCH_PERF_EN
    exp_sc = m_stall_cnt;
    exp_dc = m_disc_cnt;
`else
    exp_sc = 32'd0;
    exp_dc = 32'd0;
`endif
    if (!r) begin
      check_eq("perf_stall_cnt", bus.perf_stall_cnt, exp_sc);
      check_eq("perf_discard_cnt", bus.perf_discard_cnt, exp_dc);
    end
    rank     = exc ? 3 : er ? 2 : br ? 1 : 0;
    tgt      = exc ? ExcVec : er ? epc_v : brt_v;
    e_req    = 1'b0;
    e_stall  = 1'b1;
    e_disc   = 1'b0;
    e_err    = 1'b0;
    chk_next = 1'b0;
    e_next   = ResetPc;
    if (r) begin
      chk_next    = 1'b1;
      m_fetching  = 1'b0;
      m_held      = 1'b0;
      m_err_rep   = 1'b0;
      m_pend_rank = 0;
    end else if (m_fetching) begin
      e_req = 1'b1;
      if (ack) begin
        if (rank != 0 && rank >= m_pend_rank) dest = tgt;
        else if (m_pend_rank != 0) dest = m_pend_pc;
        else dest = pc_reg + 32'd4;
        e_disc      = (rank != 0) || (m_pend_rank != 0);
        m_pend_rank = 0;
        if (!stl) begin
          e_stall = 1'b0;
          e_next  = dest;
        end else begin
          m_fetching = 1'b0;
          m_held     = 1'b1;
          m_hold_pc  = dest;
        end
      end else if (rank != 0 && rank >= m_pend_rank) begin
        m_pend_rank = rank;
        m_pend_pc   = tgt;
      end
    end else if (m_held) begin
      if (rank != 0) begin
        e_stall = 1'b0;
        e_next  = tgt;
      end else if (!stl) begin
        e_stall = 1'b0;
        e_next  = m_hold_pc;
      end
    end else begin
      e_err     = (pc_reg[1:0] != 2'b00) && !m_err_rep;
      m_err_rep = (pc_reg[1:0] != 2'b00) && (rank == 0);
      if (rank != 0) begin
        e_stall = 1'b0;
        e_next  = tgt;
      end else begin
        chk_next = 1'b1;
        if (pc_reg[1:0] == 2'b00) m_fetching = 1'b1;
      end
    end
    if (!e_stall) begin
      chk_next   = 1'b1;
      m_held     = 1'b0;
      m_fetching = (e_next[1:0] == 2'b00);
    end
    check_eq("inst_req", bus.inst_req, e_req);
    check_eq("stallF", bus.stallF, e_stall);
    check_eq("discard", bus.discard, e_disc);
    check_eq("addr_err", bus.addr_err, e_err);
    check_eq("inst_addr", bus.inst_addr, pc_reg);
    if (chk_next) check_eq("pc_next", bus.pc_next, e_next);
    if (r) begin
      m_stall_cnt = 32'd0;
      m_disc_cnt  = 32'd0;
      pc_reg      = ResetPc;
    end else begin
      if (e_req && e_stall) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e_disc) m_disc_cnt = m_disc_cnt + 32'd1;
      if (!e_stall) pc_reg = e_next;
    end
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] rv_epc, rv_br;
    pc_reg      = ResetPc;
    m_stall_cnt = 32'd0;
    m_disc_cnt  = 32'd0;
    m_pend_pc   = 32'd0;
    m_hold_pc   = 32'd0;
    // Reset, then straight-line fetches acked two cycles after each request.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    nop();
    nop(); nop();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("seq_pc_next_1", bus.pc_next, 32'hbfc00004);
    nop(); nop();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("seq_pc_next_2", bus.pc_next, 32'hbfc00008);
    // Branch one cycle before ack.
    nop();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h80001000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("br_discard", bus.discard, 32'd1);
    check_eq("br_pc_next", bus.pc_next, 32'h80001000);
    nop();
    check_eq("br_fetch_addr", bus.inst_addr, 32'h80001000);
    // Branch, exception, later branch all before the ack: exception must win.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h80002000);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h80003000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("exc_pc_next", bus.pc_next, ExcVec);
    // Ack under a 4-cycle downstream stall.
    nop();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("hold_req", bus.inst_req, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("hold_release_pc", bus.pc_next, 32'hbfc00384);
    nop();
    check_eq("hold_resume_req", bus.inst_req, 32'd1);
    // ERET to a misaligned EPC, then recover through an exception.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80000002, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    nop();
    check_eq("misal_addr_err", bus.addr_err, 32'd1);
    nop();
    check_eq("misal_err_pulse", bus.addr_err, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    nop();
    check_eq("recover_addr", bus.inst_addr, ExcVec);
    // Reset mid-fetch followed by a stray ack.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("rst_stray_ack_stall", bus.stallF, 32'd1);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rv_epc = $urandom;
      rv_br  = $urandom;
      if ($urandom_range(0, 7) != 0) rv_epc[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) rv_br[1:0] = 2'b00;
      cycle(($urandom_range(0, 199) == 0),
            m_fetching ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 5) == 0),
            rv_epc, rv_br);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
